// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: op codes, FSM states, step sizes.
// Build option: SHIFT_SEQ_STEP4_EN adds a shift-by-4 step (lower latency, same results).
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        STEP_1 = 2'b00,
        STEP_2 = 2'b01,
        STEP_4 = 2'b10
    } step_e;

    localparam logic [4:0] STEP_1_AMT = 5'd1;
    localparam logic [4:0] STEP_2_AMT = 5'd2;
    localparam logic [4:0] STEP_4_AMT = 5'd4;

    function automatic logic [4:0] step_amount(input step_e s);
        case (s)
            STEP_2:  step_amount = STEP_2_AMT;
            STEP_4:  step_amount = STEP_4_AMT;
            default: step_amount = STEP_1_AMT;
        endcase
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// Combinational fixed-step shift stage: shifts data by 1, 2 or 4 in the direction set by op.
// Left path is plain fixed wiring; right path fills with zero (SRL) or the sign bit (SRA).
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  op_e              op_i,
    input  step_e            step_i,
    output logic [WIDTH-1:0] data_o
);

    logic             fill;
    logic [WIDTH-1:0] sl1, sl2, sl4;
    logic [WIDTH-1:0] sr1, sr2, sr4;

    assign fill = (op_i == OP_SRA) ? data_i[WIDTH-1] : 1'b0;

    assign sl1 = {data_i[WIDTH-2:0], 1'b0};
    assign sl2 = {data_i[WIDTH-3:0], 2'b00};
    assign sl4 = {data_i[WIDTH-5:0], 4'b0000};
    assign sr1 = {fill, data_i[WIDTH-1:1]};
    assign sr2 = {{2{fill}}, data_i[WIDTH-1:2]};
    assign sr4 = {{4{fill}}, data_i[WIDTH-1:4]};

    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_SLL: begin
                case (step_i)
                    STEP_2:  data_o = sl2;
                    STEP_4:  data_o = sl4;
                    default: data_o = sl1;
                endcase
            end
            OP_SRL, OP_SRA: begin
                case (step_i)
                    STEP_2:  data_o = sr2;
                    STEP_4:  data_o = sr4;
                    default: data_o = sr1;
                endcase
            end
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA controller: applies one fixed-size step per cycle until rem reaches 0.
// Build option: SHIFT_SEQ_STEP4_EN enables the shift-by-4 step (priority 4, 2, 1).
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WIDTH-1:0]   result,
    output state_e             dbg_state_o
);

    // Handshake: start is accepted on a rising edge only when the FSM is in IDLE or DONE;
    // done pulses for exactly one cycle and result stays stable until the next accept.

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   work_q, work_d;

    step_e              step_sel;
    logic [SHAMT_W-1:0] step_amt;
    logic [WIDTH-1:0]   step_data;
    op_e                op_in;

    assign op_in = op_e'(op);

    always_comb begin
        step_sel = STEP_1;
        if (rem_q >= SHAMT_W'(2)) step_sel = STEP_2;
`ifdef SHIFT_SEQ_STEP4_EN
        if (rem_q >= SHAMT_W'(4)) step_sel = STEP_4;
`endif
    end

    assign step_amt = SHAMT_W'(step_amount(step_sel));

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data_i (work_q),
        .op_i   (op_q),
        .step_i (step_sel),
        .data_o (step_data)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        work_d  = work_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d    = op_in;
                    work_d  = operand;
                    rem_d   = shamt;
                    // Zero shifts and illegal ops skip straight to DONE with the operand untouched.
                    state_d = (shamt == '0 || op_in == OP_ILL) ? S_DONE : S_SHIFT;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d  = step_data;
                rem_d   = rem_q - step_amt;
                state_d = (rem_d == '0) ? S_DONE : S_SHIFT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_SLL;
            rem_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
        end
    end

    assign busy        = (state_q == S_SHIFT);
    assign done        = (state_q == S_DONE);
    assign err         = (state_q == S_DONE) && (op_q == OP_ILL);
    assign result      = work_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed, table-driven bench for shift_sequencer plus hand-written multi-cycle sequences.
// Build option: SHIFT_SEQ_STEP4_EN selects the shorter expected latencies.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;
  state_e      dbg_state;

  int n_cmp;
  int n_bad;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .operand     (operand),
    .shamt       (shamt),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .result      (result),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  function automatic int exp_lat(input logic [1:0] o, input logic [4:0] s);
    int n;
    if (o == 2'b11) return 1;
`ifdef SHIFT_SEQ_STEP4_EN
    n = (int'(s) / 4) + (((int'(s) % 4) >= 2) ? 1 : 0) + (int'(s) % 2);
`else
    n = (int'(s) / 2) + (int'(s) % 2);
`endif
    return n + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one request from the current time (posedge+1 or idle); returns in the done cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] er, input logic ee,
                        input bit inject);
    int  lat;
    int  busy_cnt;
    bit  seen;
    op = o; operand = d; shamt = s; start = 1'b1;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0;
        if (inject) begin
          start = 1'b1; op = 2'b00; operand = 32'hFFFF_FFFF; shamt = 5'd1;
        end
      end else if (c == 2) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat(o, s)));
    check({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat(o, s) - 1));
    check({name, " result"}, result, er);
    check({name, " err"}, {31'd0, err}, {31'd0, ee});
    check({name, " busy at done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int done_seen;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; operand = '0; shamt = '0;

    vecs[0]  = '{2'b00, 32'h0000_0001,  5'd5, 32'h0000_0020, 1'b0};
    vecs[1]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{2'b01, 32'hF000_0000,  5'd0, 32'hF000_0000, 1'b0};
    vecs[3]  = '{2'b11, 32'h1234_5678,  5'd7, 32'h1234_5678, 1'b1};
    vecs[4]  = '{2'b01, 32'h8000_0000,  5'd4, 32'h0800_0000, 1'b0};
    vecs[5]  = '{2'b10, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF, 1'b0};
    vecs[6]  = '{2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0};
    vecs[7]  = '{2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0};
    vecs[8]  = '{2'b10, 32'h8000_0001,  5'd1, 32'hC000_0000, 1'b0};
    vecs[9]  = '{2'b00, 32'h1234_5678,  5'd3, 32'h91A2_B3C0, 1'b0};
    vecs[10] = '{2'b10, 32'hF0F0_0000,  5'd6, 32'hFFC3_C000, 1'b0};
    vecs[11] = '{2'b01, 32'h0000_ABCD,  5'd2, 32'h0000_2AF3, 1'b0};

    // reset state
    #12;
    check("reset busy",   {31'd0, busy}, 32'd0);
    check("reset done",   {31'd0, done}, 32'd0);
    check("reset err",    {31'd0, err},  32'd0);
    check("reset result", result, 32'd0);
    check("reset state",  32'(dbg_state), 32'(S_IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // table: consecutive entries are issued back-to-back in the DONE cycle
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].operand, vecs[i].shamt,
             vecs[i].exp_res, vecs[i].exp_err, 1'b0);
    end

    // DONE falls to IDLE without a new request; result is held
    @(posedge clk); #1;
    check("idle after done", {30'd0, busy, done}, 32'd0);
    check("idle state", 32'(dbg_state), 32'(S_IDLE));
    check("result held", result, 32'h0000_2AF3);

    // start during SHIFT is ignored
    @(posedge clk); #1;
    run_op("ignore start", 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b1);
    @(posedge clk); #1;

    // reset in cycle 3 of a 20-bit shift aborts with no done
    op = 2'b00; operand = 32'h0000_0001; shamt = 5'd20; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy before abort", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy",   {31'd0, busy}, 32'd0);
    check("abort done",   {31'd0, done}, 32'd0);
    check("abort err",    {31'd0, err},  32'd0);
    check("abort result", result, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("no done after abort", 32'(done_seen), 32'd0);
    run_op("after reset", 2'b00, 32'h0000_0001, 5'd20, 32'h0010_0000, 1'b0, 1'b0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle variable shifter controller for the 32-bit MIPS datapath. It executes SLL/SRL/SRA (and their variable forms) by sequencing a fixed-step shift stage (by 2, by 1, optionally by 4) over several cycles instead of using a full barrel shifter. It sits beside the ALU. The control unit issues a start/done handshake and stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32: data width; only 32 is supported.
- `SHAMT_W`, 5: shift-amount width; equals log2(`WIDTH`).

Ports (clock and reset first):
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a shift; sampled only when the block can accept.
- `op` in 2: operation code: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
- `operand` in 32: value to shift; latched on accept.
- `shamt` in 5: shift amount 0..31; latched on accept.
- `busy` out 1: high while shifting; the control unit stalls on it.
- `done` out 1: one-cycle pulse when `result` is valid.
- `err` out 1: high together with `done` when the accepted `op` was 11.
- `result` out 32: shifted value; held stable from `done` until the next accept.

## Operation
- The state machine has three states: IDLE, SHIFT, DONE.
- **Accept:** `start` is accepted only in IDLE or DONE. On accept, latch `op`, `operand` into the working register, and `shamt` into the remaining-count register `rem`.
- **Transitions:**
  - IDLE → SHIFT on accept with `shamt` ≠ 0 and legal `op`.
  - IDLE → DONE on accept with `shamt` = 0 or `op` = 11.
  - SHIFT → SHIFT while `rem` after the current step is ≠ 0.
  - SHIFT → DONE when `rem` after the current step is 0.
  - DONE → SHIFT or DONE on a back-to-back accept, using the same rules as IDLE.
  - DONE → IDLE otherwise.
- **Step selection in SHIFT:**
  - If `rem` ≥ 2: shift by 2 and subtract 2 from `rem`.
  - Otherwise: shift by 1 and subtract 1.
  - Exactly one step is applied per cycle.
- **Shift fill:**
  - SLL fills zeros at the LSBs.
  - SRL fills zeros at the MSBs.
  - SRA replicates the latched bit 31 into the MSBs.
- **Illegal op (11):** `result` equals `operand` unchanged, `err` is 1 in DONE, and no shift cycles run.
- **`start` during SHIFT:** ignored. It is not queued, and the latched operands are unchanged.
- **Output decode:**
  - `busy` = 1 in SHIFT, 0 in IDLE and DONE.
  - `done` = 1 only in DONE.
  - `err` = 0 except in DONE after an illegal op.
- **Reset values:** state IDLE, `result` 0, `rem` 0, `busy` 0, `done` 0, `err` 0. Reset asserted mid-SHIFT aborts the operation immediately; no `done` pulse follows.

## Timing
- Cycle 0: `start` is sampled high in IDLE.
- Cycles 1..N: SHIFT, with N = floor(`shamt`/2) + (`shamt` mod 2).
- Cycle N+1: DONE, with `done` = 1.
- Total latency from accept to `done`: N+1 cycles.
- `shamt` = 0: `done` in cycle 1 (latency 1).
- Worst case (`shamt` = 31, default build): 16 SHIFT cycles, `done` in cycle 17.
- Back-to-back throughput: a new accept in the DONE cycle removes the idle bubble.
- `result` is registered. Intermediate values are visible on `result` during SHIFT but are not guaranteed valid until `done`.

## Configuration
- Macro: `SHIFT_SEQ_STEP4_EN`.
- **Defined:** adds a shift-by-4 step. Step priority is 4, then 2, then 1:
  - N = floor(`shamt`/4) + ((`shamt` mod 4) ≥ 2) + (`shamt` mod 2).
  - `shamt` = 31 takes 9 SHIFT cycles, so `done` arrives in cycle 10.
- **Undefined:** only the 2 and 1 steps exist, with N as given in Timing.
- Functional results are identical in both builds; only latency differs.

## Structure
- Shared package `shift_seq_pkg` holds:
  - the op encodings (`OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_ILL`);
  - the state enum (`S_IDLE`, `S_SHIFT`, `S_DONE`);
  - the step-size constants.
- Sub-module `shift_step`: purely combinational. Takes data, op and a step select (1/2/4) and returns the data shifted by that step. It reuses the fixed left-by-2 wiring style for the left path.
- The controller owns the state machine, the `rem` counter, the working register and the output decode.

## Test plan
- SLL, `operand` 0x00000001, `shamt` 5 (default build) → steps 2, 2, 1; `result` 0x00000020; `done` in cycle 4; `busy` high in cycles 1–3.
- SRA, `operand` 0x80000000, `shamt` 31 → `result` 0xFFFFFFFF.
  - Default build: `done` in cycle 17.
  - With `SHIFT_SEQ_STEP4_EN`: `done` in cycle 10.
- SRL, `operand` 0xF0000000, `shamt` 0 → `done` in cycle 1, `result` 0xF0000000, `busy` never high.
- `start` pulsed with new operands during SHIFT → ignored; the original result (e.g. SRL 0x80000000 >> 4 = 0x08000000) completes on schedule.
- `op` = 11, `operand` 0x12345678 → `done` and `err` high in cycle 1, `result` 0x12345678.
- `rst_n` driven low in cycle 3 of a `shamt` = 20 shift → all outputs 0 immediately, no `done`; a fresh accept after release works normally.
